// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the 6502-style fetch sequencer.
//   fetch_state_t  - sequencer state encoding (also exported for debug)
//   OP_*           - opcodes with special length/behaviour
//   op_len()       - opcode -> instruction length in bytes (1..3)
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_OPER1 = 3'd2,
    ST_OPER2 = 3'd3,
    ST_EXEC  = 3'd4
  } fetch_state_t;

  localparam logic [7:0] OP_BRK = 8'h00;
  localparam logic [7:0] OP_JSR = 8'h20;
  localparam logic [7:0] OP_RTI = 8'h40;
  localparam logic [7:0] OP_RTS = 8'h60;

  // Opcode layout is aaa_bbb_cc: cc selects the instruction group and bbb
  // the addressing mode within that group. Length follows the mode:
  // immediate/zero-page/indexed-indirect/relative = 2, absolute forms = 3,
  // implied/accumulator = 1. The cc=11 group has no documented opcodes and
  // simply reuses the cc=01 mode lengths.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd2;
    case (op[1:0])
      2'b01, 2'b11: begin
        if (op[4:2] == 3'b011 || op[4:2] == 3'b110 || op[4:2] == 3'b111)
          len = 2'd3;
        else
          len = 2'd2;
      end
      2'b10: begin
        case (op[4:2])
          3'b010, 3'b100, 3'b110: len = 2'd1;
          3'b011, 3'b111:         len = 2'd3;
          default:                len = 2'd2;
        endcase
      end
      default: begin
        case (op[4:2])
          3'b000: begin
            case (op)
              OP_BRK:         len = 2'd2;
              OP_JSR:         len = 2'd3;
              OP_RTI, OP_RTS: len = 2'd1;
              default:        len = 2'd2;
            endcase
          end
          3'b010, 3'b110: len = 2'd1;
          3'b011, 3'b111: len = 2'd3;
          default:        len = 2'd2;
        endcase
      end
    endcase
    return len;
  endfunction

endpackage

// File: rtl/op_len_dec.sv
// op_len_dec: combinational opcode length decoder.
//   opcode - candidate opcode byte
//   len    - instruction length in bytes (1..3)
module op_len_dec
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = op_len(opcode);

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer. Pulls an opcode plus 0..2 operand
// bytes off the data bus, then presents the complete instruction to execute.
//   PHI0      - clock, rising edge
//   n_RES     - synchronous active-low reset
//   DB_IN     - data bus read value
//   RDY       - 1 advance, 0 stall (everything held)
//   INT_PEND  - interrupt request, sampled only in FETCH
//   EX_DONE   - execute accepted the presented instruction
//   n_IPC     - 0 = PC unit increments this cycle
//   IR/OPL/OPH- instruction register and operand bytes
//   IR_VALID  - IR/OPL/OPH hold a complete instruction
//   SYNC      - current cycle is an opcode fetch
//   INT_TAKEN - one-cycle pulse after a BRK was injected
//   state_dbg - current sequencer state
//
// Handshake to execute: IR_VALID is the valid, EX_DONE the ready. The
// instruction is transferred on a rising edge where IR_VALID=1, EX_DONE=1
// and RDY=1; until then IR/OPL/OPH and IR_VALID stay stable. EX_DONE is
// ignored whenever IR_VALID=0.
module fetch_seq
  import fetch_pkg::*;
(
  input  logic         PHI0,
  input  logic         n_RES,
  input  logic [7:0]   DB_IN,
  input  logic         RDY,
  input  logic         INT_PEND,
  input  logic         EX_DONE,
  output logic         n_IPC,
  output logic [7:0]   IR,
  output logic [7:0]   OPL,
  output logic [7:0]   OPH,
  output logic         IR_VALID,
  output logic         SYNC,
  output logic         INT_TAKEN,
  output fetch_state_t state_dbg
);

  fetch_state_t state;
  logic [1:0]   dec_len;
  logic [1:0]   len_q;
  logic         advance_pc;

  // Decoder looks at the bus directly: the length is only needed in the
  // FETCH cycle, when the opcode is on DB_IN.
  op_len_dec u_op_len_dec (
    .opcode (DB_IN),
    .len    (dec_len)
  );

  always_ff @(posedge PHI0) begin
    if (!n_RES) begin
      state     <= ST_RST;
      IR        <= 8'h00;
      OPL       <= 8'h00;
      OPH       <= 8'h00;
      len_q     <= 2'd0;
      INT_TAKEN <= 1'b0;
    end else begin
      // Pulse only: cleared on every cycle it is not being set.
      INT_TAKEN <= 1'b0;
      if (RDY) begin
        case (state)
          ST_RST: state <= ST_FETCH;
          ST_FETCH: begin
            OPL <= 8'h00;
            OPH <= 8'h00;
            if (INT_PEND) begin
              // Injected BRK: bus byte discarded, no operand fetch.
              IR        <= OP_BRK;
              len_q     <= 2'd1;
              INT_TAKEN <= 1'b1;
              state     <= ST_EXEC;
            end else begin
              IR    <= DB_IN;
              len_q <= dec_len;
              state <= (dec_len >= 2'd2) ? ST_OPER1 : ST_EXEC;
            end
          end
          ST_OPER1: begin
            OPL   <= DB_IN;
            state <= (len_q == 2'd3) ? ST_OPER2 : ST_EXEC;
          end
          ST_OPER2: begin
            OPH   <= DB_IN;
            state <= ST_EXEC;
          end
          ST_EXEC: begin
            if (EX_DONE) state <= ST_FETCH;
          end
          default: state <= ST_RST;
        endcase
      end
    end
  end

  // PC advances on every consumed bus byte; an injected BRK consumes none.
  assign advance_pc = RDY && ((state == ST_FETCH && !INT_PEND) ||
                              state == ST_OPER1 || state == ST_OPER2);
  assign n_IPC      = ~advance_pc;
  assign SYNC       = (state == ST_FETCH);
  assign IR_VALID   = (state == ST_EXEC);
  assign state_dbg  = state;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  logic         n_RES, RDY, INT_PEND, EX_DONE;
  logic [7:0]   DB_IN;
  logic         n_IPC, IR_VALID, SYNC, INT_TAKEN;
  logic [7:0]   IR, OPL, OPH;
  fetch_state_t state_dbg;

  fetch_seq dut (
    .PHI0(PHI0), .n_RES(n_RES), .DB_IN(DB_IN), .RDY(RDY),
    .INT_PEND(INT_PEND), .EX_DONE(EX_DONE), .n_IPC(n_IPC), .IR(IR),
    .OPL(OPL), .OPH(OPH), .IR_VALID(IR_VALID), .SYNC(SYNC),
    .INT_TAKEN(INT_TAKEN), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic n_res, input logic rdy, input logic ip,
                       input logic exd, input logic [7:0] db);
    n_RES = n_res; RDY = rdy; INT_PEND = ip; EX_DONE = exd; DB_IN = db;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge PHI0);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       n_res, rdy, ip, exd;
    logic [7:0] db;
    logic       sync, valid, nipc, taken;
    logic [7:0] ir, opl, oph;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic n_res, input logic rdy, input logic ip,
                             input logic exd, input logic [7:0] db,
                             input logic sync, input logic valid, input logic nipc,
                             input logic taken, input logic [7:0] ir,
                             input logic [7:0] opl, input logic [7:0] oph);
    vec_t r;
    r.n_res = n_res; r.rdy = rdy; r.ip = ip; r.exd = exd; r.db = db;
    r.sync = sync; r.valid = valid; r.nipc = nipc; r.taken = taken;
    r.ir = ir; r.opl = opl; r.oph = oph;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Instruction-level view: how many bytes of the current instruction have
  // been taken, and how many it needs. cnt==0 means waiting for an opcode.
  int         len_tab[256];
  logic [7:0] pool[$];
  logic [7:0] ops1[$] = '{8'h40, 8'h60, 8'h08, 8'h28, 8'h48, 8'h68, 8'h88, 8'hA8,
                          8'hC8, 8'hE8, 8'h18, 8'h38, 8'h58, 8'h78, 8'h98, 8'hB8,
                          8'hD8, 8'hF8, 8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'h8A, 8'hAA,
                          8'hCA, 8'hEA, 8'h9A, 8'hBA};
  logic [7:0] ops2[$] = '{8'h00, 8'hA9, 8'hA2, 8'hA0, 8'hC0, 8'hE0, 8'h10, 8'h30,
                          8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h05, 8'h65,
                          8'h85, 8'hA5, 8'h01, 8'h11, 8'h15, 8'h06, 8'h16, 8'h26,
                          8'h86, 8'h96, 8'hB6, 8'hA6, 8'h24, 8'h84, 8'h94, 8'hB4,
                          8'hC4, 8'hE4, 8'h09, 8'h29, 8'h49, 8'h69, 8'hC9, 8'hE9};
  logic [7:0] ops3[$] = '{8'h20, 8'h4C, 8'h6C, 8'h2C, 8'h8C, 8'hAC, 8'hCC, 8'hEC,
                          8'hBC, 8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD,
                          8'hED, 8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9,
                          8'hF9, 8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'h9D, 8'hBD, 8'hDD,
                          8'hFD, 8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'h8E, 8'hAE, 8'hCE,
                          8'hEE, 8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE, 8'hBE};

  bit         m_rst;
  int         m_cnt, m_need;
  logic [7:0] m_ir, m_opl, m_oph;
  logic       m_taken;
  logic [23:0] exp_q[$];

  function automatic bit m_sync(); return !m_rst && m_cnt == 0; endfunction
  function automatic bit m_exec(); return !m_rst && m_cnt != 0 && m_cnt == m_need; endfunction

  task automatic model_reset();
    m_rst = 1; m_cnt = 0; m_need = 0;
    m_ir = 8'h00; m_opl = 8'h00; m_oph = 8'h00; m_taken = 1'b0;
  endtask

  task automatic model_step(input logic n_res, input logic rdy, input logic ip,
                            input logic exd, input logic [7:0] db);
    bit was_exec;
    was_exec = m_exec();
    if (!n_res) begin
      model_reset();
      return;
    end
    m_taken = 1'b0;
    if (!rdy) return;
    if (m_rst) m_rst = 0;
    else if (m_sync()) begin
      m_opl = 8'h00; m_oph = 8'h00; m_cnt = 1;
      if (ip) begin m_ir = 8'h00; m_need = 1; m_taken = 1'b1; end
      else begin m_ir = db; m_need = len_tab[db]; end
    end else if (was_exec) begin
      if (exd) m_cnt = 0;
    end else begin
      if (m_cnt == 1) m_opl = db; else m_oph = db;
      m_cnt++;
    end
    if (!was_exec && m_exec()) exp_q.push_back({m_ir, m_opl, m_oph});
  endtask

  function automatic fetch_state_t m_state();
    if (m_rst)    return ST_RST;
    if (m_sync()) return ST_FETCH;
    if (m_exec()) return ST_EXEC;
    return (m_cnt == 1) ? ST_OPER1 : ST_OPER2;
  endfunction

  logic prev_valid;

  task automatic random_compare();
    logic exp_nipc;
    exp_nipc = !(RDY && !m_rst && !m_exec() && !(m_sync() && INT_PEND));
    chk("r_sync",   SYNC,      m_sync());
    chk("r_valid",  IR_VALID,  m_exec());
    chk("r_nipc",   n_IPC,     exp_nipc);
    chk("r_taken",  INT_TAKEN, m_taken);
    chk("r_ir",     IR,        m_ir);
    chk("r_opl",    OPL,       m_opl);
    chk("r_oph",    OPH,       m_oph);
    chk("r_state",  state_dbg, m_state());
    // Scoreboard: each new instruction presented must match the model's.
    if (IR_VALID === 1'b1 && prev_valid !== 1'b1) begin
      chk("r_ins_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("r_ins", {IR, OPL, OPH}, exp_q.pop_front());
    end
    prev_valid = IR_VALID;
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < 256; i++) len_tab[i] = 2;
    foreach (ops1[i]) begin len_tab[ops1[i]] = 1; pool.push_back(ops1[i]); end
    foreach (ops2[i]) begin len_tab[ops2[i]] = 2; pool.push_back(ops2[i]); end
    foreach (ops3[i]) begin len_tab[ops3[i]] = 3; pool.push_back(ops3[i]); end

    //               rst rdy ip exd db      sync vld nipc tkn ir     opl    oph
    vecs.push_back(v(0, 1, 0, 0, 8'h00,   0, 0, 1, 0, 8'h00, 8'h00, 8'h00)); // reset state
    vecs.push_back(v(1, 1, 0, 0, 8'h00,   0, 0, 1, 0, 8'h00, 8'h00, 8'h00)); // RST
    // LDA #$42
    vecs.push_back(v(1, 1, 0, 0, 8'hA9,   1, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h42,   0, 0, 0, 0, 8'hA9, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'hFF,   0, 1, 1, 0, 8'hA9, 8'h42, 8'h00));
    vecs.push_back(v(1, 1, 0, 1, 8'hFF,   0, 1, 1, 0, 8'hA9, 8'h42, 8'h00));
    // JMP $1234
    vecs.push_back(v(1, 1, 0, 0, 8'h4C,   1, 0, 0, 0, 8'hA9, 8'h42, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h34,   0, 0, 0, 0, 8'h4C, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h12,   0, 0, 0, 0, 8'h4C, 8'h34, 8'h00));
    vecs.push_back(v(1, 1, 0, 1, 8'h00,   0, 1, 1, 0, 8'h4C, 8'h34, 8'h12));
    // NOP, EX_DONE immediately
    vecs.push_back(v(1, 1, 0, 0, 8'hEA,   1, 0, 0, 0, 8'h4C, 8'h34, 8'h12));
    vecs.push_back(v(1, 1, 0, 1, 8'h00,   0, 1, 1, 0, 8'hEA, 8'h00, 8'h00));
    // interrupt injection; INT_PEND held into EXEC is ignored
    vecs.push_back(v(1, 1, 1, 0, 8'hA9,   1, 0, 1, 0, 8'hEA, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 1, 0, 8'hA9,   0, 1, 1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 1, 8'h00,   0, 1, 1, 0, 8'h00, 8'h00, 8'h00));
    // STA $0200 with a 3-cycle stall in OPER1
    vecs.push_back(v(1, 1, 0, 0, 8'h8D,   1, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(1, 0, 0, 0, 8'h55,   0, 0, 1, 0, 8'h8D, 8'h00, 8'h00));
    vecs.push_back(v(1, 0, 1, 1, 8'h66,   0, 0, 1, 0, 8'h8D, 8'h00, 8'h00));
    vecs.push_back(v(1, 0, 0, 0, 8'h77,   0, 0, 1, 0, 8'h8D, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h8D, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h02,   0, 0, 0, 0, 8'h8D, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 1, 8'h00,   0, 1, 1, 0, 8'h8D, 8'h00, 8'h02));
    // LDA $5678 aborted by reset in OPER2
    vecs.push_back(v(1, 1, 0, 0, 8'hAD,   1, 0, 0, 0, 8'h8D, 8'h00, 8'h02));
    vecs.push_back(v(1, 1, 0, 0, 8'h78,   0, 0, 0, 0, 8'hAD, 8'h00, 8'h00));
    vecs.push_back(v(0, 1, 0, 0, 8'h56,   0, 0, 0, 0, 8'hAD, 8'h78, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h00,   0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'hEA,   1, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 1, 8'h00,   0, 1, 1, 0, 8'hEA, 8'h00, 8'h00));
    vecs.push_back(v(1, 1, 0, 0, 8'h00,   1, 0, 0, 0, 8'hEA, 8'h00, 8'h00)); // no bubble

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].n_res, vecs[i].rdy, vecs[i].ip, vecs[i].exd, vecs[i].db);
      @(negedge PHI0);
      chk($sformatf("v%0d_sync", i),  SYNC,      vecs[i].sync);
      chk($sformatf("v%0d_valid", i), IR_VALID,  vecs[i].valid);
      chk($sformatf("v%0d_nipc", i),  n_IPC,     vecs[i].nipc);
      chk($sformatf("v%0d_taken", i), INT_TAKEN, vecs[i].taken);
      chk($sformatf("v%0d_ir", i),    IR,        vecs[i].ir);
      chk($sformatf("v%0d_opl", i),   OPL,       vecs[i].opl);
      chk($sformatf("v%0d_oph", i),   OPH,       vecs[i].oph);
      @(posedge PHI0);
      #1;
    end

    // Randomized run against the model.
    do_reset();
    model_reset();
    prev_valid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      logic [7:0] db;
      db = pool[$urandom_range(0, pool.size() - 1)];
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), db);
      @(negedge PHI0);
      random_compare();
      @(posedge PHI0);
      #1;
      model_step(n_RES, RDY, INT_PEND, EX_DONE, DB_IN);
    end
    @(negedge PHI0);
    random_compare();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
